cpu_clock_controller: RTL and testbench
=======================================

// Module: cpu_clock_controller
// PURPOSE
//  Run/stop/single-step sequencer for the microprocessor's slow clock domain.
//  Contains a free-running tick divider and issues one-cycle cpu_en strobes
//  that advance the processor by one instruction cycle.
//  Sits between the board push-buttons and the CPU core; cpu_halt from the core stops execution.
// PARAMETERS
//  DIV    25000000  tick period in clkin cycles; legal range DIV >= 2
//  CNT_W  32        divider counter width; 2**CNT_W > DIV
//  CYC_W  16        width of executed-cycle counter
// PORTS
//  clkin      in   1      system clock; all logic on posedge
//  clr        in   1      asynchronous active-high reset
//  run_req    in   1      request free-run; level, debounced upstream, synchronous to clkin
//  stop_req   in   1      request stop; same signal class as run_req
//  step_req   in   1      request one CPU cycle; same signal class as run_req
//  cpu_halt   in   1      level from CPU core: core has executed HALT
//  tick       out  1      divider strobe; high 1 clkin cycle every DIV cycles
//  cpu_en     out  1      CPU clock enable; high 1 clkin cycle per executed CPU cycle
//  running    out  1      1 while in RUN state
//  cycle_cnt  out  CYC_W  number of cpu_en strobes issued since clr; wraps modulo 2**CYC_W
// BEHAVIOUR
//  Reset (clr=1, async): cnt=0, tick=0, state=STOP, cpu_en=0, running=0, cycle_cnt=0,
//   edge-detect history regs=0. Takes effect immediately. Clears any pending step.
//  Divider: cnt increments every posedge, independent of state.
//   - At cnt==DIV-1: cnt<=0 and tick<=1; otherwise tick<=0.
//   - tick is registered; first tick is high in the cycle after the DIV-th posedge following clr release.
//  Request detection: *_evt = req & ~req_q; req_q registered each cycle. Only rising edges count;
//   a held request produces one event.
//  States (2-bit, registered): STOP=00, RUN=01, STEP=10. 11 is unreachable and maps to STOP next cycle.
//   - STOP: run_evt -> RUN; else step_evt -> STEP.
//     If run_evt and step_evt occur in the same cycle, go to RUN.
//     While cpu_halt=1, run_evt and step_evt are ignored (stay STOP).
//   - RUN: stop_evt or cpu_halt -> STOP. run_evt and step_evt are ignored.
//   - STEP: stop_evt or cpu_halt -> STOP with no strobe. Else on tick -> STOP.
//     run_evt and step_evt are ignored.
//  cpu_en = tick & ~cpu_halt & ~stop_evt & (state==RUN | state==STEP).
//   - Combinational from registered terms; never high twice within DIV cycles.
//   - STEP issues exactly one strobe: the first tick after entering STEP.
//   - A tick in the same cycle as the STOP->STEP transition does not count.
//  running = (state==RUN), registered-state decode; rises the cycle after run_evt.
//  cycle_cnt: +1 on each posedge where cpu_en=1; all-ones+1 -> 0.
//  Simultaneous stop_evt and tick in RUN/STEP: stop wins, no strobe.
//  clr mid-STEP or mid-RUN: no further cpu_en until a new request arrives after release.
// TESTING (DIV=4, CYC_W=4 unless noted)
//  1. Reset, then release clr, 12 idle cycles.
//     -> cpu_en=0, running=0, cycle_cnt=0; tick high on cycles 4, 8, 12 after release.
//  2. 1-cycle run_req pulse, then 20 cycles.
//     -> running=1 from next cycle; cpu_en coincident with every tick (5 strobes); cycle_cnt=5.
//  3. From STOP, step_req held high for 20 cycles.
//     -> exactly one cpu_en on first tick after entry; state back to STOP; cycle_cnt=1.
//  4. In RUN, raise cpu_halt on a tick cycle.
//     -> cpu_en stays 0 that cycle; running=0 next cycle.
//     A run_req pulse while cpu_halt=1 leaves running=0.
//  5. Same-cycle events:
//     run_req+step_req edges in STOP -> RUN.
//     stop_req edge coincident with tick in RUN -> no cpu_en, STOP.
//  6. Run for 17 strobes -> cycle_cnt=1 (wrap).
//     Assert clr two cycles into STEP -> no cpu_en; all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_clock_controller_if.sv
// Bundle of push-button requests, core halt and sequencer outputs shared
// between the board-facing side and the run/stop/step clock controller.
interface cpu_clock_controller_if #(
    parameter int CYC_W = 16
);
    logic             run_req;
    logic             stop_req;
    logic             step_req;
    logic             cpu_halt;
    logic             tick;
    logic             cpu_en;
    logic             running;
    logic [CYC_W-1:0] cycle_cnt;

    modport master (
        output run_req, stop_req, step_req, cpu_halt,
        input  tick, cpu_en, running, cycle_cnt
    );

    modport slave (
        input  run_req, stop_req, step_req, cpu_halt,
        output tick, cpu_en, running, cycle_cnt
    );
endinterface

// File: rtl/cpu_clock_controller.sv
// Run/stop/single-step sequencer for the slow CPU clock domain. A free-running
// divider produces a tick every DIV clkin cycles; in RUN every tick becomes a
// cpu_en strobe, in STEP only the first tick after entry does.
module cpu_clock_controller #(
    parameter int DIV   = 25000000,
    parameter int CNT_W = 32,
    parameter int CYC_W = 16
) (
    input  logic                  clkin,
    input  logic                  clr,
    cpu_clock_controller_if.slave bus
);

    typedef enum logic [1:0] {
        STOP = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             tick_q;
    logic             run_q;
    logic             stop_q;
    logic             step_q;
    logic             run_evt;
    logic             stop_evt;
    logic             step_evt;
    logic             cpu_en;
    logic [CYC_W-1:0] cycle_cnt;
    state_t           state;
    state_t           state_next;

    assign run_evt  = bus.run_req  & ~run_q;
    assign stop_evt = bus.stop_req & ~stop_q;
    assign step_evt = bus.step_req & ~step_q;

    // Free-running tick divider; wraps at DIV-1 and registers a one-cycle strobe
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            cnt    <= '0;
            tick_q <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt    <= '0;
            tick_q <= 1'b1;
        end else begin
            cnt    <= cnt + 1'b1;
            tick_q <= 1'b0;
        end
    end

    // Request history so that only rising edges of the held levels act as events
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            run_q  <= 1'b0;
            stop_q <= 1'b0;
            step_q <= 1'b0;
        end else begin
            run_q  <= bus.run_req;
            stop_q <= bus.stop_req;
            step_q <= bus.step_req;
        end
    end

    // Sequencer state register
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            state <= STOP;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; halt blocks starting, and stop/halt override a pending step
    always_comb begin
        state_next = STOP;
        case (state)
            STOP: begin
                state_next = STOP;
                if (!bus.cpu_halt) begin
                    if (run_evt) begin
                        state_next = RUN;
                    end else if (step_evt) begin
                        state_next = STEP;
                    end
                end
            end
            RUN: begin
                state_next = (stop_evt || bus.cpu_halt) ? STOP : RUN;
            end
            STEP: begin
                if (stop_evt || bus.cpu_halt || tick_q) begin
                    state_next = STOP;
                end else begin
                    state_next = STEP;
                end
            end
            default: begin
                state_next = STOP;
            end
        endcase
    end

    assign cpu_en = tick_q & ~bus.cpu_halt & ~stop_evt & ((state == RUN) | (state == STEP));

    // Count every strobe actually delivered to the core, wrapping naturally
    always_ff @(posedge clkin or posedge clr) begin
        if (clr) begin
            cycle_cnt <= '0;
        end else if (cpu_en) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end

    assign bus.tick      = tick_q;
    assign bus.cpu_en    = cpu_en;
    assign bus.running   = (state == RUN);
    assign bus.cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_cpu_clock_controller.sv
// Self-checking bench for cpu_clock_controller: a cycle model pushes the
// expected outputs of each cycle into a scoreboard when the stimulus is
// driven, and they are popped and compared when the DUT is sampled.
module tb_cpu_clock_controller;

    localparam int DIV   = 4;
    localparam int CYC_W = 4;

    typedef struct {
        bit tick;
        bit en;
        bit run;
        int cyc;
    } exp_t;

    logic clkin = 1'b0;
    logic clr   = 1'b1;

    cpu_clock_controller_if #(.CYC_W(CYC_W)) bus();

    cpu_clock_controller #(
        .DIV   (DIV),
        .CNT_W (8),
        .CYC_W (CYC_W)
    ) dut (
        .clkin (clkin),
        .clr   (clr),
        .bus   (bus)
    );

    // Free-running system clock, period 10
    always #5 clkin = ~clkin;

    exp_t sb[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    int m_cnt;
    bit m_tick;
    int m_state;
    bit m_rq, m_sq, m_tq;
    int m_cyc;

    int strobes;
    int ticks;
    int last_en;
    int last_run;
    int last_cyc;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        n_compared++;
        if (actual != expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_cnt   = 0;
        m_tick  = 0;
        m_state = 0;
        m_rq    = 0;
        m_sq    = 0;
        m_tq    = 0;
        m_cyc   = 0;
    endtask

    // One clkin cycle: drive inputs just after a posedge, predict, sample at negedge
    task automatic applyStimulus(input bit run, input bit stop, input bit step, input bit halt);
        exp_t e;
        exp_t got;
        bit   run_e, stop_e, step_e;
        int   nxt;
        bus.run_req  = run;
        bus.stop_req = stop;
        bus.step_req = step;
        bus.cpu_halt = halt;
        run_e  = run  && !m_rq;
        stop_e = stop && !m_sq;
        step_e = step && !m_tq;
        e.tick = m_tick;
        e.en   = m_tick && !halt && !stop_e && (m_state == 1 || m_state == 2);
        e.run  = (m_state == 1);
        e.cyc  = m_cyc;
        sb.push_back(e);
        nxt = m_state;
        if (m_state == 0) begin
            if (!halt && run_e) nxt = 1;
            else if (!halt && step_e) nxt = 2;
        end else if (m_state == 1) begin
            if (stop_e || halt) nxt = 0;
        end else begin
            if (stop_e || halt || m_tick) nxt = 0;
        end
        m_state = nxt;
        if (e.en) m_cyc = (m_cyc + 1) % (1 << CYC_W);
        if (m_cnt == DIV - 1) begin
            m_cnt  = 0;
            m_tick = 1;
        end else begin
            m_cnt  = m_cnt + 1;
            m_tick = 0;
        end
        m_rq = run;
        m_sq = stop;
        m_tq = step;
        @(negedge clkin);
        if (sb.size() == 0) begin
            checkOutput("sb_empty", 0, 1);
        end else begin
            got = sb.pop_front();
            checkOutput("tick",      int'(bus.tick),      int'(got.tick));
            checkOutput("cpu_en",    int'(bus.cpu_en),    int'(got.en));
            checkOutput("running",   int'(bus.running),   int'(got.run));
            checkOutput("cycle_cnt", int'(bus.cycle_cnt), got.cyc);
        end
        last_en  = int'(bus.cpu_en);
        last_run = int'(bus.running);
        last_cyc = int'(bus.cycle_cnt);
        strobes += int'(bus.cpu_en);
        ticks   += int'(bus.tick);
        @(posedge clkin);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0);
    endtask

    // Idle until the coming cycle carries a tick, bounded
    task automatic waitTick();
        int guard = 0;
        while (!m_tick && guard < 10) begin
            idle();
            guard++;
        end
        if (!m_tick) checkOutput("tick_wait_timeout", 0, 1);
    endtask

    // Assert clr mid-cycle, check outputs clear at once, release after a posedge
    task automatic doReset();
        clr = 1'b1;
        #1;
        checkOutput("rst_tick",      int'(bus.tick),      0);
        checkOutput("rst_cpu_en",    int'(bus.cpu_en),    0);
        checkOutput("rst_running",   int'(bus.running),   0);
        checkOutput("rst_cycle_cnt", int'(bus.cycle_cnt), 0);
        @(posedge clkin);
        #1;
        clr = 1'b0;
        modelReset();
        sb.delete();
    endtask

    initial begin
        int guard;
        bus.run_req  = 1'b0;
        bus.stop_req = 1'b0;
        bus.step_req = 1'b0;
        bus.cpu_halt = 1'b0;
        strobes = 0;
        ticks   = 0;
        #1;
        doReset();

        // Idle after reset: three ticks, no strobes
        ticks = 0; strobes = 0;
        repeat (13) idle();
        checkOutput("t1_ticks", ticks, 3);
        checkOutput("t1_strobes", strobes, 0);

        // Free run for 20 cycles after a run pulse
        applyStimulus(1, 0, 0, 0);
        strobes = 0;
        repeat (20) idle();
        checkOutput("t2_strobes", strobes, 5);
        applyStimulus(0, 1, 0, 0);
        checkOutput("t2_cycle_cnt", last_cyc, 5);
        idle();
        checkOutput("t2_stopped", last_run, 0);

        // Held step request yields exactly one strobe
        strobes = 0;
        repeat (20) applyStimulus(0, 0, 1, 0);
        checkOutput("t3_strobes", strobes, 1);
        idle();
        checkOutput("t3_running", last_run, 0);
        checkOutput("t3_cycle_cnt", last_cyc, 6);

        // Halt on a tick cycle in RUN, then a run pulse under halt
        applyStimulus(1, 0, 0, 0);
        idle();
        idle();
        waitTick();
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_halt_en", last_en, 0);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_halt_running", last_run, 0);
        applyStimulus(1, 0, 0, 1);
        applyStimulus(0, 0, 0, 1);
        checkOutput("t4_run_under_halt", last_run, 0);
        idle();

        // Simultaneous run+step goes to RUN; stop on a tick suppresses the strobe
        applyStimulus(1, 0, 1, 0);
        idle();
        checkOutput("t5_run_wins", last_run, 1);
        waitTick();
        applyStimulus(0, 1, 0, 0);
        checkOutput("t5_stop_tick_en", last_en, 0);
        idle();
        checkOutput("t5_stopped", last_run, 0);

        // Counter wrap after 17 strobes, then clr in the middle of a step
        doReset();
        applyStimulus(1, 0, 0, 0);
        strobes = 0;
        guard = 0;
        while (strobes < 17 && guard < 200) begin
            idle();
            guard++;
        end
        checkOutput("t6_strobes", strobes, 17);
        applyStimulus(0, 1, 0, 0);
        idle();
        checkOutput("t6_wrap", last_cyc, 1);
        waitTick();
        strobes = 0;
        applyStimulus(0, 0, 1, 0);
        idle();
        idle();
        doReset();
        checkOutput("t6_step_no_en", strobes, 0);
        repeat (8) idle();
        checkOutput("t6_after_clr_en", strobes, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
